// File: rtl/kp_filter_ctrl.sv
// Frame-level sequencer for one channel's Gaussian filter pipeline: flush, enable, frame counting.
// Optional watchdog enabled by defining KP_FILTER_CTRL_WDOG_EN.
module kp_filter_ctrl #(
  parameter int unsigned LINE_LENGTH  = 640,
  parameter int unsigned LINE_COUNT   = 480,
  parameter int unsigned PIX_BYPASS   = LINE_LENGTH * LINE_COUNT,
  parameter int unsigned PIX_FILTER   = (LINE_LENGTH - 2) * (LINE_COUNT - 2),
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 65535,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_continuous,
  input  logic             i_enable_req,
  input  logic             i_frame_start,
  input  logic             i_pix_out,
  input  logic             i_clr_err,
  output logic             o_enable,
  output logic             o_flush,
  output logic             o_busy,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic             o_overrun,
  output logic             o_timeout,
  output logic [1:0]       o_state
);

  localparam int unsigned PIX_MAX = (PIX_BYPASS > PIX_FILTER) ? PIX_BYPASS : PIX_FILTER;
  localparam int unsigned PIX_W   = $clog2(PIX_MAX) + 1;
  localparam int unsigned FL_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [PIX_W-1:0] TGT_BYPASS = PIX_W'(PIX_BYPASS);
  localparam logic [PIX_W-1:0] TGT_FILTER = PIX_W'(PIX_FILTER);
  localparam logic [FL_W-1:0]  FL_LAST    = FL_W'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFlush  = 2'd1,
    StArm    = 2'd2,
    StActive = 2'd3
  } state_e;

  state_e             r_state, w_state_d;
  logic [FL_W-1:0]    r_flush_cnt, w_flush_cnt_d;
  logic [PIX_W-1:0]   r_pix_cnt, w_pix_cnt_d;
  logic [PIX_W-1:0]   r_target, w_target_d;
  logic               r_enable, w_enable_d;
  logic               r_flush, w_flush_d;
  logic               r_busy, w_busy_d;
  logic               r_frame_done, w_frame_done_d;
  logic [CNT_W-1:0]   r_frame_cnt, w_frame_cnt_d;
  logic               r_overrun, w_overrun_d;
  logic               r_stop_pend, w_stop_pend_d;

  logic w_active;
  logic w_complete;
  logic w_overrun_set;
  logic w_timeout_set;
  logic w_stop_now;
  logic w_enter_flush;

  assign w_active   = (r_state == StActive);
  assign w_complete = w_active && i_pix_out && (r_pix_cnt == (r_target - PIX_W'(1)));
  // Completion takes priority over a coincident frame start.
  assign w_overrun_set = w_active && i_frame_start && !w_complete;
  assign w_stop_now    = r_stop_pend || (w_active && i_stop);

`ifdef KP_FILTER_CTRL_WDOG_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_d;
  logic              r_timeout, w_timeout_d;

  assign w_timeout_set = w_active && !i_pix_out && (r_idle_cnt == IDLE_LAST);
  assign w_idle_cnt_d  = (!w_active || i_pix_out) ? '0 : r_idle_cnt + IDLE_W'(1);
  assign w_timeout_d   = w_timeout_set ? 1'b1 : (i_clr_err ? 1'b0 : r_timeout);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_idle_cnt <= w_idle_cnt_d;
      r_timeout  <= w_timeout_d;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout_set    = 1'b0;
  assign o_timeout        = 1'b0;
`endif

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= StIdle;
      r_flush_cnt  <= '0;
      r_pix_cnt    <= '0;
      r_target     <= '0;
      r_enable     <= 1'b0;
      r_flush      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_overrun    <= 1'b0;
      r_stop_pend  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_flush_cnt  <= w_flush_cnt_d;
      r_pix_cnt    <= w_pix_cnt_d;
      r_target     <= w_target_d;
      r_enable     <= w_enable_d;
      r_flush      <= w_flush_d;
      r_busy       <= w_busy_d;
      r_frame_done <= w_frame_done_d;
      r_frame_cnt  <= w_frame_cnt_d;
      r_overrun    <= w_overrun_d;
      r_stop_pend  <= w_stop_pend_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_d = StFlush;
      end
      StFlush: begin
        if (r_flush_cnt == FL_LAST) w_state_d = r_stop_pend ? StIdle : StArm;
      end
      StArm: begin
        if (i_stop) w_state_d = StIdle;
        else if (i_frame_start) w_state_d = StActive;
      end
      StActive: begin
        if (w_complete) w_state_d = (i_continuous && !w_stop_now) ? StFlush : StIdle;
        else if (w_overrun_set || w_timeout_set) w_state_d = StFlush;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_enter_flush = (w_state_d == StFlush) && (r_state != StFlush);

  always_comb begin
    w_enable_d     = w_enter_flush ? i_enable_req : r_enable;
    w_target_d     = r_target;
    if (w_enter_flush) w_target_d = i_enable_req ? TGT_FILTER : TGT_BYPASS;
    w_flush_d      = (w_state_d == StFlush);
    w_busy_d       = (w_state_d != StIdle);
    w_frame_done_d = w_complete;
    w_frame_cnt_d  = w_complete ? r_frame_cnt + CNT_W'(1) : r_frame_cnt;
    w_overrun_d    = w_overrun_set ? 1'b1 : (i_clr_err ? 1'b0 : r_overrun);
    w_flush_cnt_d  = (r_state == StFlush) ? r_flush_cnt + FL_W'(1) : '0;

    w_stop_pend_d = r_stop_pend;
    if (w_active && i_stop) w_stop_pend_d = 1'b1;
    if (w_state_d == StIdle) w_stop_pend_d = 1'b0;

    w_pix_cnt_d = r_pix_cnt;
    if (r_state == StArm && w_state_d == StActive) w_pix_cnt_d = '0;
    else if (w_active && i_pix_out && !w_complete) w_pix_cnt_d = r_pix_cnt + PIX_W'(1);
  end

  assign o_enable     = r_enable;
  assign o_flush      = r_flush;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_overrun    = r_overrun;
  assign o_state      = r_state;

endmodule

// File: tb/tb_kp_filter_ctrl.sv
// Directed self-checking bench for kp_filter_ctrl (8x4 frames, 4-cycle flush, 16-cycle watchdog).
module tb_kp_filter_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rstn, i_start, i_stop, i_continuous, i_enable_req;
  logic       i_frame_start, i_pix_out, i_clr_err;
  logic       o_enable, o_flush, o_busy, o_frame_done, o_overrun, o_timeout;
  logic [3:0] o_frame_cnt;
  logic [1:0] o_state;

  int n_cmp = 0;
  int n_err = 0;

  kp_filter_ctrl #(
    .LINE_LENGTH (8),
    .LINE_COUNT  (4),
    .FLUSH_CYCLES(4),
    .TIMEOUT     (16),
    .CNT_W       (4)
  ) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_start      (i_start),
    .i_stop       (i_stop),
    .i_continuous (i_continuous),
    .i_enable_req (i_enable_req),
    .i_frame_start(i_frame_start),
    .i_pix_out    (i_pix_out),
    .i_clr_err    (i_clr_err),
    .o_enable     (o_enable),
    .o_flush      (o_flush),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_frame_cnt  (o_frame_cnt),
    .o_overrun    (o_overrun),
    .o_timeout    (o_timeout),
    .o_state      (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_continuous = 1'b0; i_enable_req = 1'b0;
    i_frame_start = 1'b0; i_pix_out = 1'b0; i_clr_err = 1'b0;
    tick(); tick();
    i_rstn = 1'b1;
    tick();
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget);
    int n = 0;
    while (o_state !== st && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1; tick(); i_start = 1'b0;
  endtask

  task automatic pulse_fs();
    i_frame_start = 1'b1; tick(); i_frame_start = 1'b0;
  endtask

  // Pulses i_pix_out n times with gap idle cycles between pulses; counts frame_done seen.
  task automatic send_pixels(input int n, input int gap, output int dones);
    dones = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          if (o_frame_done === 1'b1) dones++;
        end
      end
      i_pix_out = 1'b1; tick(); i_pix_out = 1'b0;
      if (o_frame_done === 1'b1) dones++;
    end
  endtask

  task automatic test_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_continuous = 1'b0; i_enable_req = 1'b0;
    i_frame_start = 1'b0; i_pix_out = 1'b0; i_clr_err = 1'b0;
    tick(); tick();
    n_cmp++; if ({o_enable, o_flush, o_busy, o_frame_done, o_overrun, o_timeout} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags act=%b exp=000000",
                        {o_enable, o_flush, o_busy, o_frame_done, o_overrun, o_timeout}); end
    n_cmp++; if (o_state !== 2'd0) begin
      n_err++; $display("FAIL reset_state act=%0d exp=0", o_state); end
    n_cmp++; if (o_frame_cnt !== 4'd0) begin
      n_err++; $display("FAIL reset_cnt act=%0d exp=0", o_frame_cnt); end
    i_rstn = 1'b1; tick();
    i_frame_start = 1'b1; i_pix_out = 1'b1; tick(); i_frame_start = 1'b0; i_pix_out = 1'b0;
    n_cmp++; if (o_state !== 2'd0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL idle_ignore act=%0d/%b exp=0/0", o_state, o_busy); end
  endtask

  task automatic test_basic_frame();
    int fl = 0;
    int d;
    do_reset();
    i_enable_req = 1'b1;
    pulse_start();
    n_cmp++; if (o_state !== 2'd1 || o_busy !== 1'b1 || o_enable !== 1'b1) begin
      n_err++; $display("FAIL basic_entry act=%0d/%b/%b exp=1/1/1", o_state, o_busy, o_enable); end
    for (int i = 0; i < 10; i++) begin
      if (o_flush === 1'b1) fl++;
      if (o_state === 2'd2) break;
      tick();
    end
    n_cmp++; if (fl != 4) begin
      n_err++; $display("FAIL basic_flush_len act=%0d exp=4", fl); end
    n_cmp++; if (o_state !== 2'd2 || o_flush !== 1'b0) begin
      n_err++; $display("FAIL basic_arm act=%0d/%b exp=2/0", o_state, o_flush); end
    pulse_fs();
    n_cmp++; if (o_state !== 2'd3) begin
      n_err++; $display("FAIL basic_active act=%0d exp=3", o_state); end
    send_pixels(11, 1, d);
    n_cmp++; if (d != 0 || o_state !== 2'd3) begin
      n_err++; $display("FAIL basic_11px act=%0d/%0d exp=0/3", d, o_state); end
    send_pixels(1, 0, d);
    n_cmp++; if (o_frame_done !== 1'b1 || o_frame_cnt !== 4'd1) begin
      n_err++; $display("FAIL basic_done act=%b/%0d exp=1/1", o_frame_done, o_frame_cnt); end
    n_cmp++; if (o_state !== 2'd0 || o_busy !== 1'b0 || o_enable !== 1'b1) begin
      n_err++; $display("FAIL basic_idle act=%0d/%b/%b exp=0/0/1", o_state, o_busy, o_enable); end
    tick();
    n_cmp++; if (o_frame_done !== 1'b0) begin
      n_err++; $display("FAIL basic_done_pulse act=%b exp=0", o_frame_done); end
  endtask

  task automatic test_bypass_continuous();
    int d;
    do_reset();
    i_enable_req = 1'b0; i_continuous = 1'b1;
    pulse_start();
    wait_state(2'd2, 10);
    n_cmp++; if (o_state !== 2'd2 || o_enable !== 1'b0) begin
      n_err++; $display("FAIL byp_arm act=%0d/%b exp=2/0", o_state, o_enable); end
    pulse_fs();
    send_pixels(31, 0, d);
    n_cmp++; if (d != 0) begin
      n_err++; $display("FAIL byp_f1_early act=%0d exp=0", d); end
    send_pixels(1, 0, d);
    n_cmp++; if (o_frame_done !== 1'b1 || o_state !== 2'd1 || o_frame_cnt !== 4'd1) begin
      n_err++; $display("FAIL byp_f1_done act=%b/%0d/%0d exp=1/1/1",
                        o_frame_done, o_state, o_frame_cnt); end
    wait_state(2'd2, 10);
    pulse_fs();
    send_pixels(16, 0, d);
    i_enable_req = 1'b1;
    send_pixels(15, 0, d);
    n_cmp++; if (o_enable !== 1'b0 || d != 0) begin
      n_err++; $display("FAIL byp_f2_enable act=%b/%0d exp=0/0", o_enable, d); end
    send_pixels(1, 0, d);
    n_cmp++; if (o_frame_done !== 1'b1 || o_frame_cnt !== 4'd2 || o_enable !== 1'b1) begin
      n_err++; $display("FAIL byp_f2_done act=%b/%0d/%b exp=1/2/1",
                        o_frame_done, o_frame_cnt, o_enable); end
    wait_state(2'd2, 10);
    pulse_fs();
    send_pixels(11, 0, d);
    n_cmp++; if (d != 0) begin
      n_err++; $display("FAIL byp_f3_early act=%0d exp=0", d); end
    send_pixels(1, 0, d);
    n_cmp++; if (o_frame_done !== 1'b1 || o_frame_cnt !== 4'd3) begin
      n_err++; $display("FAIL byp_f3_done act=%b/%0d exp=1/3", o_frame_done, o_frame_cnt); end
    i_continuous = 1'b0;
  endtask

  task automatic test_overrun();
    int d;
    do_reset();
    i_enable_req = 1'b1;
    pulse_start();
    wait_state(2'd2, 10);
    pulse_fs();
    send_pixels(5, 0, d);
    pulse_fs();
    n_cmp++; if (o_overrun !== 1'b1 || o_frame_done !== 1'b0 || o_state !== 2'd1) begin
      n_err++; $display("FAIL ovr_set act=%b/%b/%0d exp=1/0/1", o_overrun, o_frame_done, o_state); end
    wait_state(2'd2, 10);
    n_cmp++; if (o_state !== 2'd2 || o_frame_cnt !== 4'd0) begin
      n_err++; $display("FAIL ovr_arm act=%0d/%0d exp=2/0", o_state, o_frame_cnt); end
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
    n_cmp++; if (o_overrun !== 1'b0) begin
      n_err++; $display("FAIL ovr_clr act=%b exp=0", o_overrun); end
    pulse_fs();
    send_pixels(2, 0, d);
    i_frame_start = 1'b1; i_clr_err = 1'b1; tick(); i_frame_start = 1'b0; i_clr_err = 1'b0;
    n_cmp++; if (o_overrun !== 1'b1 || o_state !== 2'd1) begin
      n_err++; $display("FAIL ovr_set_wins act=%b/%0d exp=1/1", o_overrun, o_state); end
    wait_state(2'd2, 10);
    i_clr_err = 1'b1; tick(); i_clr_err = 1'b0;
    pulse_fs();
    send_pixels(11, 0, d);
    i_pix_out = 1'b1; i_frame_start = 1'b1; tick(); i_pix_out = 1'b0; i_frame_start = 1'b0;
    n_cmp++; if (o_frame_done !== 1'b1 || o_overrun !== 1'b0 || o_state !== 2'd0) begin
      n_err++; $display("FAIL ovr_coincide act=%b/%b/%0d exp=1/0/0",
                        o_frame_done, o_overrun, o_state); end
    n_cmp++; if (o_frame_cnt !== 4'd1) begin
      n_err++; $display("FAIL ovr_coincide_cnt act=%0d exp=1", o_frame_cnt); end
  endtask

  task automatic test_stop_pending();
    int d;
    do_reset();
    i_enable_req = 1'b1; i_continuous = 1'b1;
    pulse_start();
    wait_state(2'd2, 10);
    pulse_fs();
    send_pixels(4, 2, d);
    pulse_start();
    n_cmp++; if (o_state !== 2'd3) begin
      n_err++; $display("FAIL extra_start act=%0d exp=3", o_state); end
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    n_cmp++; if (o_state !== 2'd3) begin
      n_err++; $display("FAIL stop_no_abort act=%0d exp=3", o_state); end
    send_pixels(8, 0, d);
    n_cmp++; if (o_frame_done !== 1'b1 || o_state !== 2'd0 || o_busy !== 1'b0) begin
      n_err++; $display("FAIL stop_done act=%b/%0d/%b exp=1/0/0", o_frame_done, o_state, o_busy); end
    pulse_start();
    wait_state(2'd2, 10);
    n_cmp++; if (o_state !== 2'd2) begin
      n_err++; $display("FAIL stop_cleared act=%0d exp=2", o_state); end
    i_stop = 1'b1; i_frame_start = 1'b1; tick(); i_stop = 1'b0; i_frame_start = 1'b0;
    n_cmp++; if (o_state !== 2'd0) begin
      n_err++; $display("FAIL stop_wins act=%0d exp=0", o_state); end
    i_continuous = 1'b0;
  endtask

  task automatic test_watchdog();
    do_reset();
    pulse_start();
    wait_state(2'd2, 10);
    pulse_fs();
    repeat (15) tick();
    n_cmp++; if (o_state !== 2'd3 || o_timeout !== 1'b0) begin
      n_err++; $display("FAIL wdog_pre act=%0d/%b exp=3/0", o_state, o_timeout); end
    tick();
`ifdef KP_FILTER_CTRL_WDOG_EN
    n_cmp++; if (o_timeout !== 1'b1 || o_state !== 2'd1) begin
      n_err++; $display("FAIL wdog_fire act=%b/%0d exp=1/1", o_timeout, o_state); end
`else
    repeat (40) tick();
    n_cmp++; if (o_timeout !== 1'b0 || o_state !== 2'd3) begin
      n_err++; $display("FAIL wdog_off act=%b/%0d exp=0/3", o_timeout, o_state); end
`endif
  endtask

  task automatic test_reset_midflush();
    do_reset();
    i_enable_req = 1'b1;
    pulse_start();
    tick();
    n_cmp++; if (o_flush !== 1'b1 || o_state !== 2'd1) begin
      n_err++; $display("FAIL midflush_pre act=%b/%0d exp=1/1", o_flush, o_state); end
    #2 i_rstn = 1'b0;
    #1;
    n_cmp++; if (o_flush !== 1'b0 || o_state !== 2'd0 || o_busy !== 1'b0 || o_enable !== 1'b0) begin
      n_err++; $display("FAIL async_reset act=%b/%0d/%b/%b exp=0/0/0/0",
                        o_flush, o_state, o_busy, o_enable); end
    tick();
    i_rstn = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    int d;
    int total = 0;
    do_reset();
    i_enable_req = 1'b1;
    for (int f = 0; f < 16; f++) begin
      pulse_start();
      wait_state(2'd2, 10);
      pulse_fs();
      send_pixels(12, 0, d);
      total += d;
      if (f == 14) begin
        n_cmp++; if (o_frame_cnt !== 4'd15) begin
          n_err++; $display("FAIL wrap_15 act=%0d exp=15", o_frame_cnt); end
      end
    end
    n_cmp++; if (o_frame_cnt !== 4'd0 || total != 16) begin
      n_err++; $display("FAIL wrap_0 act=%0d/%0d exp=0/16", o_frame_cnt, total); end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_bypass_continuous();
    test_overrun();
    test_stop_pending();
    test_watchdog();
    test_reset_midflush();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
